// File: rtl/lcd_timing_ctrl_pkg.sv
// lcd_timing_ctrl_pkg: shared LCD mode encoding, register addresses and bit positions
package lcd_timing_ctrl_pkg;
    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } lcd_mode_e;
    localparam logic [15:0] ADDR_LCDC = 16'hFF40;
    localparam logic [15:0] ADDR_STAT = 16'hFF41;
    localparam logic [15:0] ADDR_LY   = 16'hFF44;
    localparam logic [15:0] ADDR_LYC  = 16'hFF45;
    localparam int LCDC_EN = 7;
    // STAT enables are stored as a 4-bit field holding STAT[6:3]
    localparam int STAT_LYC_IE = 3;
    localparam int STAT_OAM_IE = 2;
    localparam int STAT_VBL_IE = 1;
    localparam int STAT_HBL_IE = 0;
endpackage

// File: rtl/lcd_timing_ctrl_stat_irq.sv
// lcd_stat_irq: ORs the enabled STAT sources into one line and pulses on its rising edge
module lcd_stat_irq
    import lcd_timing_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [3:0] i_stat_en,
    input  logic       i_coinc,
    input  lcd_mode_e  i_mode,
    output logic       o_irq
);
    logic w_line;
    logic r_prev;
    assign w_line = i_en & ((i_stat_en[STAT_LYC_IE] & i_coinc) |
                            (i_stat_en[STAT_OAM_IE] & (i_mode == MODE_OAM)) |
                            (i_stat_en[STAT_VBL_IE] & (i_mode == MODE_VBLANK)) |
                            (i_stat_en[STAT_HBL_IE] & (i_mode == MODE_HBLANK)));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= w_line;
    end
    assign o_irq = w_line & ~r_prev;
endmodule

// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: LCD dot/line counters, PPU mode decode, LY/LYC compare and CPU register file
module lcd_timing_ctrl
    import lcd_timing_ctrl_pkg::*;
#(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int DRAW_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_dot_en,
    input  logic [15:0] i_reg_addr,
    input  logic        i_reg_we,
    input  logic        i_reg_re,
    input  logic [7:0]  i_reg_wdata,
    output logic [7:0]  o_reg_rdata,
    output logic        o_reg_rvalid,
    output logic [7:0]  o_ly,
    output logic [1:0]  o_mode,
    output logic        o_line_start,
    output logic        o_vblank_irq,
    output logic        o_stat_irq,
    output logic        o_frame_done
);
    localparam int DW = $clog2(DOTS_PER_LINE);
    logic [DW-1:0] r_dot, w_dot_n;
    logic [7:0]    r_ly, w_ly_n, r_lcdc, w_lcdc_n, r_lyc, w_lyc_n, r_rdata, w_rd_mux;
    logic [3:0]    r_stat, w_stat_n;
    lcd_mode_e     r_mode, w_mode_n;
    logic          r_run, w_run_n, w_frame_done_n;
    logic          r_line_start, r_vblank_irq, r_frame_done, r_rvalid;
    logic          w_wr_lcdc, w_wr_stat, w_wr_ly, w_wr_lyc, w_owned, w_coinc, w_last_dot, w_last_line;

    assign w_wr_lcdc   = i_reg_we && i_reg_addr == ADDR_LCDC;
    assign w_wr_stat   = i_reg_we && i_reg_addr == ADDR_STAT;
    assign w_wr_ly     = i_reg_we && i_reg_addr == ADDR_LY;
    assign w_wr_lyc    = i_reg_we && i_reg_addr == ADDR_LYC;
    assign w_owned     = i_reg_addr inside {ADDR_LCDC, ADDR_STAT, ADDR_LY, ADDR_LYC};
    assign w_coinc     = r_ly == r_lyc;
    assign w_last_dot  = r_dot == DW'(DOTS_PER_LINE - 1);
    assign w_last_line = r_ly == 8'(TOTAL_LINES - 1);
    assign w_rd_mux    = (i_reg_addr == ADDR_LCDC) ? r_lcdc :
                         (i_reg_addr == ADDR_STAT) ? {1'b1, r_stat, w_coinc, r_mode} :
                         (i_reg_addr == ADDR_LY)   ? r_ly : r_lyc;

    // r_run distinguishes "enabled, waiting for the first dot" from "scanning"
    always_comb begin
        w_lcdc_n       = w_wr_lcdc ? i_reg_wdata : r_lcdc;
        w_stat_n       = w_wr_stat ? i_reg_wdata[6:3] : r_stat;
        w_lyc_n        = w_wr_lyc ? i_reg_wdata : r_lyc;
        w_dot_n        = r_dot;
        w_ly_n         = r_ly;
        w_run_n        = r_run;
        w_frame_done_n = 1'b0;
        if (!w_lcdc_n[LCDC_EN]) begin
            w_dot_n = '0;
            w_ly_n  = '0;
            w_run_n = 1'b0;
        end else if (w_wr_ly) begin
            w_dot_n = '0;
            w_ly_n  = '0;
            w_run_n = r_run | i_dot_en;
        end else if (i_dot_en) begin
            w_run_n = 1'b1;
            if (r_run) begin
                w_dot_n        = w_last_dot ? '0 : r_dot + 1'b1;
                w_ly_n         = !w_last_dot ? r_ly : w_last_line ? 8'd0 : r_ly + 8'd1;
                w_frame_done_n = w_last_dot & w_last_line;
            end
        end
        w_mode_n = !w_run_n                          ? MODE_HBLANK :
                   w_ly_n >= 8'(VISIBLE_LINES)       ? MODE_VBLANK :
                   w_dot_n < DW'(OAM_DOTS)           ? MODE_OAM    :
                   w_dot_n < DW'(OAM_DOTS + DRAW_DOTS) ? MODE_DRAW : MODE_HBLANK;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dot        <= '0;
            r_ly         <= '0;
            r_mode       <= MODE_HBLANK;
            r_run        <= 1'b0;
            r_lcdc       <= '0;
            r_stat       <= '0;
            r_lyc        <= '0;
            r_line_start <= 1'b0;
            r_vblank_irq <= 1'b0;
            r_frame_done <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_dot        <= w_dot_n;
            r_ly         <= w_ly_n;
            r_mode       <= w_mode_n;
            r_run        <= w_run_n;
            r_lcdc       <= w_lcdc_n;
            r_stat       <= w_stat_n;
            r_lyc        <= w_lyc_n;
            r_line_start <= w_mode_n == MODE_DRAW && r_mode != MODE_DRAW;
            r_vblank_irq <= w_run_n && w_ly_n == 8'(VISIBLE_LINES) && r_ly != 8'(VISIBLE_LINES);
            r_frame_done <= w_frame_done_n;
            r_rvalid     <= i_reg_re && w_owned;
            if (i_reg_re && w_owned) r_rdata <= w_rd_mux;
        end
    end

    lcd_stat_irq u_stat_irq (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (r_lcdc[LCDC_EN]),
        .i_stat_en (r_stat),
        .i_coinc   (w_coinc),
        .i_mode    (r_mode),
        .o_irq     (o_stat_irq)
    );

    assign o_reg_rdata  = r_rdata;
    assign o_reg_rvalid = r_rvalid;
    assign o_ly         = r_ly;
    assign o_mode       = r_mode;
    assign o_line_start = r_line_start;
    assign o_vblank_irq = r_vblank_irq;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// tb_lcd_timing_ctrl: random register/dot-enable traffic checked against a tick-count reference model
module tb_lcd_timing_ctrl;
    localparam int DPL = 20, OAM = 5, DRAW = 7, VIS = 6, TOT = 9, FRAME = DPL * TOT;

    logic        clk = 1'b0, rst_n = 1'b0, dot_en = 1'b0, reg_we = 1'b0, reg_re = 1'b0;
    logic [15:0] reg_addr = 16'h0;
    logic [7:0]  reg_wdata = 8'h0;
    logic [7:0]  reg_rdata, ly;
    logic [1:0]  mode;
    logic        reg_rvalid, line_start, vblank_irq, stat_irq, frame_done;

    always #5 clk = ~clk;

    lcd_timing_ctrl #(
        .DOTS_PER_LINE (DPL),
        .OAM_DOTS      (OAM),
        .DRAW_DOTS     (DRAW),
        .VISIBLE_LINES (VIS),
        .TOTAL_LINES   (TOT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dot_en     (dot_en),
        .i_reg_addr   (reg_addr),
        .i_reg_we     (reg_we),
        .i_reg_re     (reg_re),
        .i_reg_wdata  (reg_wdata),
        .o_reg_rdata  (reg_rdata),
        .o_reg_rvalid (reg_rvalid),
        .o_ly         (ly),
        .o_mode       (mode),
        .o_line_start (line_start),
        .o_vblank_irq (vblank_irq),
        .o_stat_irq   (stat_irq),
        .o_frame_done (frame_done)
    );

    int n_vec = 0, n_err = 0;
    // model: ticks elapsed since the scan started; dot/ly/mode follow arithmetically
    int         m_t, e_ly, e_mode;
    bit         m_run, e_ls, e_vb, e_fd, e_irq, e_line, e_rv;
    logic [7:0] m_lcdc, m_lyc, e_rd;
    logic [3:0] m_sten;
    logic [15:0] addrs [6] = '{16'hFF40, 16'hFF41, 16'hFF44, 16'hFF45, 16'hFF00, 16'hFF42};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_run = 0; m_lcdc = 0; m_lyc = 0; m_sten = 0;
        e_ly = 0; e_mode = 0; e_ls = 0; e_vb = 0; e_fd = 0; e_irq = 0; e_line = 0; e_rv = 0; e_rd = 0;
    endtask

    task automatic model_step(input bit dot, input bit we, input bit re, input logic [15:0] addr, input logic [7:0] wd);
        int pl = e_ly, pm = e_mode, d;
        bit adv = 0, line;
        e_rv = re && (addr inside {16'hFF40, 16'hFF41, 16'hFF44, 16'hFF45});
        if (e_rv)
            e_rd = addr == 16'hFF40 ? m_lcdc :
                   addr == 16'hFF41 ? {1'b1, m_sten, e_ly == int'(m_lyc), 2'(e_mode)} :
                   addr == 16'hFF44 ? 8'(e_ly) : m_lyc;
        if (we && addr == 16'hFF40) m_lcdc = wd;
        if (we && addr == 16'hFF41) m_sten = wd[6:3];
        if (we && addr == 16'hFF45) m_lyc = wd;
        if (!m_lcdc[7]) begin
            m_run = 0; m_t = 0;
        end else if (we && addr == 16'hFF44) begin
            m_t = 0; m_run = m_run | dot;
        end else if (dot) begin
            if (m_run) begin m_t++; adv = 1; end
            m_run = 1;
        end
        d = m_t % DPL;
        e_ly = m_run ? (m_t / DPL) % TOT : 0;
        e_mode = !m_run ? 0 : e_ly >= VIS ? 1 : d < OAM ? 2 : d < OAM + DRAW ? 3 : 0;
        e_ls = e_mode == 3 && pm != 3;
        e_vb = e_ly == VIS && pl != VIS;
        e_fd = adv && (m_t % FRAME) == 0;
        line = m_lcdc[7] && ((m_sten[3] && e_ly == int'(m_lyc)) || (m_sten[2] && e_mode == 2) ||
                             (m_sten[1] && e_mode == 1) || (m_sten[0] && e_mode == 0));
        e_irq = line && !e_line;
        e_line = line;
    endtask

    task automatic check_outputs();
        check("ly", ly, e_ly);
        check("mode", mode, e_mode);
        check("line_start", line_start, e_ls);
        check("vblank_irq", vblank_irq, e_vb);
        check("stat_irq", stat_irq, e_irq);
        check("frame_done", frame_done, e_fd);
        check("rvalid", reg_rvalid, e_rv);
        check("rdata", reg_rdata, e_rd);
    endtask

    task automatic cyc(input bit dot, input bit we, input bit re, input logic [15:0] addr, input logic [7:0] wd);
        dot_en = dot; reg_we = we; reg_re = re; reg_addr = addr; reg_wdata = wd;
        @(posedge clk);
        model_step(dot, we, re, addr, wd);
        #1;
        check_outputs();
        dot_en = 0; reg_we = 0; reg_re = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 16'hFF00, 8'h00);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        cyc(1, 1, 0, 16'hFF40, 8'h80);
        run(FRAME + 30);
        cyc(0, 1, 0, 16'hFF45, 8'd3);
        cyc(0, 1, 0, 16'hFF41, 8'h40);
        run(DPL * 4);
        cyc(0, 0, 1, 16'hFF41, 8'h00);
        cyc(0, 1, 0, 16'hFF41, 8'h28);
        run(FRAME);
        run(DPL * 3 + 7);
        cyc(1, 1, 1, 16'hFF44, 8'h5A);
        run(3);
        cyc(0, 0, 1, 16'hFF44, 8'h00);
        cyc(0, 0, 1, 16'hFF00, 8'h00);
        cyc(1, 1, 0, 16'hFF40, 8'h00);
        run(25);
        cyc(0, 1, 0, 16'hFF40, 8'h91);
        run(10);
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            bit dot = $urandom_range(0, 9) < 7;
            bit we = 0, re = 0;
            logic [15:0] addr = addrs[$urandom_range(0, 5)];
            logic [7:0] wd = 8'($urandom);
            if (i == 2000) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs();
                @(negedge clk);
                rst_n = 1'b1;
                cyc(0, 0, 0, 16'hFF00, 8'h00);
                cyc(1, 1, 0, 16'hFF40, 8'h80);
            end
            if (r < 4) begin we = 1; addr = 16'hFF41; end
            else if (r < 8) begin we = 1; addr = 16'hFF45; wd = 8'($urandom_range(0, TOT)); end
            else if (r == 8) begin we = 1; addr = 16'hFF44; end
            else if (r == 9) begin we = 1; addr = 16'hFF40; wd[7] = $urandom_range(0, 3) != 0; end
            else if (r == 10) begin we = 1; end
            if (we) re = $urandom_range(0, 3) == 0;
            else re = r < 30;
            cyc(dot, we, re, addr, wd);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
